legv8_pc_fetch: RTL and testbench

- Fetch-stage sequencer for the LEGv8 datapath.
- Owns the program counter and computes both next-PC candidates: sequential PC+4 and branch target.
- Selects between the two candidates, issues one-outstanding-request reads to instruction memory, and presents fetched instructions to decode with stall and branch-redirect handling.
- Sits between the branch/control logic and the instruction memory port.

---
 rtl/legv8_pkg.sv | 23 ++
 rtl/legv8_pc_fetch_pc_next_sel.sv | 13 +
 rtl/legv8_pc_fetch.sv | 141 ++++++++++++++
 tb/tb_legv8_pc_fetch.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared types and constants for the LEGv8 fetch stage.
package legv8_pkg;

   localparam int          LEGV8_XLEN     = 32;
   localparam logic [31:0] LEGV8_PC_INC   = 32'd4;
   localparam logic [31:0] LEGV8_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_t;

   // Offset is a word count; the shift turns it into a byte offset, wrapping mod 2^32.
   function automatic logic [LEGV8_XLEN-1:0] branch_target(
      input logic [LEGV8_XLEN-1:0] pc,
      input logic [LEGV8_XLEN-1:0] offset
   );
      return pc + (offset << 2);
   endfunction

endpackage

// File: rtl/legv8_pc_fetch_pc_next_sel.sv
// Next-PC multiplexer: sequential PC or branch target.
module pc_next_sel
   import legv8_pkg::*;
(
   input  logic [LEGV8_XLEN-1:0] seq_pc_i,
   input  logic [LEGV8_XLEN-1:0] tgt_pc_i,
   input  logic                  sel_i,
   output logic [LEGV8_XLEN-1:0] next_pc_o
);

   assign next_pc_o = sel_i ? tgt_pc_i : seq_pc_i;

endmodule

// File: rtl/legv8_pc_fetch.sv
// LEGv8 fetch sequencer: owns the PC, issues single-outstanding imem reads and
// presents instructions to decode with stall hold and branch redirect/flush.
//
// Handshake: a request transfers on a rising edge where imem_req && imem_ready;
// imem_addr is held stable while imem_req is high. Read data is taken only in
// WAIT on imem_rvalid. Decode consumes instr_out on a cycle where
// instr_valid && !stall.
module legv8_pc_fetch
   import legv8_pkg::*;
#(
   parameter logic [31:0] RESET_PC = LEGV8_RESET_PC,
   parameter logic [31:0] PC_INC   = LEGV8_PC_INC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_pc,
   input  logic [31:0] branch_offset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_out,
   output logic [31:0] pc_out,
   output logic        instr_valid,
   output logic [1:0]  fetch_state_dbg
);

   fetch_state_t state_q;
   logic [31:0]  pc_q;
   logic [31:0]  addr_q;
   logic [31:0]  instr_q;
   logic [31:0]  pc_out_q;
   logic         req_q;
   logic         valid_q;
   logic         drop_q;

   logic         redirect;
   logic [31:0]  seq_pc;
   logic [31:0]  tgt_pc;
   logic [31:0]  next_pc;

   // Redirects are ignored in BOOT so the first fetch is always at RESET_PC.
   assign redirect = branch_taken && (state_q != BOOT);
   assign seq_pc   = pc_q + PC_INC;
   assign tgt_pc   = branch_target(branch_pc, branch_offset);

   pc_next_sel u_pc_next_sel (
      .seq_pc_i  (seq_pc),
      .tgt_pc_i  (tgt_pc),
      .sel_i     (redirect),
      .next_pc_o (next_pc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= BOOT;
         pc_q     <= RESET_PC;
         req_q    <= 1'b0;
         addr_q   <= 32'h0;
         instr_q  <= 32'h0;
         pc_out_q <= 32'h0;
         valid_q  <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         if (redirect) begin
            pc_q    <= next_pc;
            valid_q <= 1'b0;
         end
         case (state_q)
            BOOT: begin
               state_q <= REQ;
               req_q   <= 1'b1;
               addr_q  <= pc_q;
            end
            REQ: begin
               // The presented instruction was consumed in the previous cycle.
               valid_q <= 1'b0;
               if (redirect) begin
                  drop_q <= 1'b1;
               end
               if (imem_ready) begin
                  state_q <= WAIT;
                  req_q   <= 1'b0;
               end
            end
            WAIT: begin
               if (redirect && !imem_rvalid) begin
                  drop_q <= 1'b1;
               end
               if (imem_rvalid) begin
                  if (drop_q || redirect) begin
                     drop_q  <= 1'b0;
                     state_q <= REQ;
                     req_q   <= 1'b1;
                     addr_q  <= redirect ? next_pc : pc_q;
                  end else begin
                     instr_q  <= imem_rdata;
                     pc_out_q <= pc_q;
                     valid_q  <= 1'b1;
                     pc_q     <= next_pc;
                     if (stall) begin
                        state_q <= HOLD;
                     end else begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        addr_q  <= next_pc;
                     end
                  end
               end
            end
            HOLD: begin
               if (redirect) begin
                  state_q <= REQ;
                  req_q   <= 1'b1;
                  addr_q  <= next_pc;
               end else if (!stall) begin
                  state_q <= REQ;
                  req_q   <= 1'b1;
                  addr_q  <= pc_q;
                  valid_q <= 1'b0;
               end
            end
            default: begin
               state_q <= BOOT;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req        = req_q;
   assign imem_addr       = addr_q;
   assign instr_out       = instr_q;
   assign pc_out          = pc_out_q;
   assign instr_valid     = valid_q;
   assign fetch_state_dbg = state_q;

endmodule

// File: tb/tb_legv8_pc_fetch.sv
// Bench for legv8_pc_fetch: directed scenarios plus a random run, checked
// against a transaction-level reference model and a delivery queue.
`timescale 1ns/1ps
module tb_legv8_pc_fetch;
   import legv8_pkg::*;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        reset, stall, branch_taken, imem_ready, imem_rvalid;
   logic [31:0] branch_pc, branch_offset, imem_rdata;
   logic        imem_req, instr_valid;
   logic [31:0] imem_addr, instr_out, pc_out;
   logic [1:0]  dbg_state;

   always #5 clk = ~clk;

   legv8_pc_fetch dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .branch_taken    (branch_taken),
      .branch_pc       (branch_pc),
      .branch_offset   (branch_offset),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ready      (imem_ready),
      .imem_rvalid     (imem_rvalid),
      .imem_rdata      (imem_rdata),
      .instr_out       (instr_out),
      .pc_out          (pc_out),
      .instr_valid     (instr_valid),
      .fetch_state_dbg (dbg_state)
   );

   // ---------------- scoreboard / reference model ----------------
   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q[$];

   bit          m_init, m_boot, m_out, m_out_stale, m_stale_pend, m_hold;
   bit          e_req, e_valid, p_evalid;
   logic [31:0] m_fetch_pc, m_out_addr, m_cur_pc;

   bit          mem_busy;
   int          mem_cnt;
   logic [31:0] mem_addr;

   bit          p_req, p_acc, p_rst;
   logic [31:0] p_addr;
   int          acc_cnt = 0;
   logic [31:0] last_acc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: observe at the negedge, drive inputs, advance model, cross the posedge.
   // Knobs: negative = random, otherwise forced value.
   task automatic step(input int rdy, input int stl, input int br,
                       input logic [31:0] bpc, input logic [31:0] boff,
                       input int rst, input int lat);
      bit          acc, resp, redir, cap;
      logic [31:0] tgt;
      int          l;
      if (m_init) begin
         check_val("req", 32'(imem_req), 32'(e_req));
         check_val("valid", 32'(instr_valid), 32'(e_valid));
         if (imem_req && p_req && !p_acc && !p_rst)
            check_val("addr_stable", imem_addr, p_addr);
         if (imem_req && e_req && !m_stale_pend)
            check_val("fetch_addr", imem_addr, m_fetch_pc);
         if (e_valid && !p_evalid) begin
            check_val("deliv_pending", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) m_cur_pc = exp_q.pop_front();
         end
         if (e_valid) begin
            check_val("pc_out", pc_out, m_cur_pc);
            check_val("instr_out", instr_out, mem_word(m_cur_pc));
         end
      end
      p_evalid = e_valid;

      reset         = (rst > 0);
      stall         = (stl < 0) ? ($urandom_range(0, 99) < 30) : (stl > 0);
      redir         = !reset && m_init && !m_boot &&
                      ((br < 0) ? ($urandom_range(0, 99) < 5) : (br > 0));
      branch_taken  = redir;
      branch_pc     = (br < 0) ? $urandom() : bpc;
      branch_offset = (br < 0) ? (32'($urandom_range(0, 63)) - 32'd32) : boff;
      tgt           = branch_pc + branch_offset * 32'd4;
      resp          = mem_busy && (mem_cnt == 0);
      imem_rvalid   = resp;
      imem_rdata    = resp ? mem_word(mem_addr) : $urandom();
      imem_ready    = !reset && !mem_busy &&
                      ((rdy < 0) ? ($urandom_range(0, 99) < 70) : (rdy > 0));
      acc           = imem_req && imem_ready;

      if (reset) begin
         m_init = 1; m_boot = 1; m_out = 0; m_out_stale = 0; m_stale_pend = 0;
         m_hold = 0; e_req = 0; e_valid = 0; m_fetch_pc = 32'h0;
         exp_q.delete();
      end else if (m_init) begin
         if (m_boot) begin
            m_boot = 0; e_req = 1; e_valid = 0;
         end else begin
            cap = 0;
            if (resp && m_out) begin
               cap   = !m_out_stale && !redir;
               m_out = 0;
            end
            if (acc) begin
               m_out       = 1;
               m_out_stale = m_stale_pend || redir;
               m_out_addr  = m_fetch_pc;
               if (!m_out_stale) m_fetch_pc = m_fetch_pc + 32'd4;
               m_stale_pend = 0;
            end
            if (redir) begin
               m_fetch_pc = tgt;
               if (m_out) m_out_stale = 1;
               if (e_req && !acc) m_stale_pend = 1;
            end
            if (cap) begin
               exp_q.push_back(m_out_addr);
               e_valid = 1;
               m_hold  = stall;
            end else if (m_hold && stall && !redir) begin
               e_valid = 1;
            end else begin
               e_valid = 0;
               m_hold  = 0;
            end
            e_req = !m_out && !m_hold;
         end
      end

      if (resp) mem_busy = 0;
      else if (mem_busy) mem_cnt--;
      if (acc) begin
         l        = (lat < 0) ? int'($urandom_range(1, 3)) : lat;
         mem_busy = 1;
         mem_addr = imem_addr;
         mem_cnt  = l - 1;
         acc_cnt++;
         last_acc = imem_addr;
      end
      p_req  = imem_req;
      p_acc  = acc;
      p_addr = imem_addr;
      p_rst  = reset;

      @(posedge clk);
      @(negedge clk);
   endtask

   // ---------------- driver helpers ----------------
   task automatic do_reset();
      step(0, 0, 0, 32'h0, 32'h0, 1, 1);
      step(0, 0, 0, 32'h0, 32'h0, 1, 1);
   endtask

   task automatic run_until_acc(input int n, input int rdy, input int lat, input int stl);
      int start;
      int budget;
      start  = acc_cnt;
      budget = 0;
      while (acc_cnt < start + n && budget < 200) begin
         step(rdy, stl, 0, 32'h0, 32'h0, 0, lat);
         budget++;
      end
      check_val("acc_budget", 32'(acc_cnt - start), 32'(n));
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_req"},   32'(imem_req), 32'd0);
      check_val({tag, "_addr"},  imem_addr, 32'h0);
      check_val({tag, "_instr"}, instr_out, 32'h0);
      check_val({tag, "_pc"},    pc_out, 32'h0);
      check_val({tag, "_valid"}, 32'(instr_valid), 32'd0);
      check_val({tag, "_state"}, 32'(dbg_state), 32'(BOOT));
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_pc = 32'h0;
      branch_offset = 32'h0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      @(negedge clk);

      // 1: sequential fetch with single-cycle memory
      do_reset();
      check_reset_outputs("rst1");
      for (int i = 0; i < 4; i++) begin
         run_until_acc(1, 1, 1, 0);
         check_val($sformatf("seq_addr%0d", i), last_acc, 32'(4 * i));
      end

      // 2: stall holds the instruction at pc 4
      do_reset();
      run_until_acc(2, 1, 1, 0);
      step(1, 1, 0, 32'h0, 32'h0, 0, 1);
      for (int i = 0; i < 5; i++) begin
         check_val("hold_pc", pc_out, 32'h4);
         check_val("hold_instr", instr_out, 32'hA5A5_0004);
         check_val("hold_valid", 32'(instr_valid), 32'd1);
         check_val("hold_noreq", 32'(imem_req), 32'd0);
         step(1, 1, 0, 32'h0, 32'h0, 0, 1);
      end
      run_until_acc(1, 1, 1, 0);
      check_val("after_hold_addr", last_acc, 32'h8);

      // 3: redirect while waiting for addr C
      do_reset();
      run_until_acc(4, 1, 2, 0);
      check_val("wait_c_addr", last_acc, 32'hC);
      step(0, 0, 1, 32'h8, 32'hFFFF_FFFE, 0, 2);
      check_val("br_wait_valid0", 32'(instr_valid), 32'd0);
      step(0, 0, 0, 32'h0, 32'h0, 0, 1);
      check_val("br_wait_valid1", 32'(instr_valid), 32'd0);
      check_val("br_wait_req", 32'(imem_req), 32'd1);
      check_val("br_wait_addr", imem_addr, 32'h0);
      run_until_acc(1, 1, 1, 0);
      check_val("br_wait_next", last_acc, 32'h0);

      // 4: redirect in REQ while memory is not ready
      do_reset();
      step(0, 0, 0, 32'h0, 32'h0, 0, 1);
      step(0, 0, 1, 32'h0, 32'h5, 0, 1);
      for (int i = 0; i < 3; i++) begin
         check_val("br_req_addr", imem_addr, 32'h0);
         check_val("br_req_req", 32'(imem_req), 32'd1);
         step(0, 0, 0, 32'h0, 32'h0, 0, 1);
      end
      run_until_acc(1, 1, 1, 0);
      step(0, 0, 0, 32'h0, 32'h0, 0, 1);
      check_val("br_req_drop", 32'(instr_valid), 32'd0);
      check_val("br_req_addr2", imem_addr, 32'h14);
      run_until_acc(1, 1, 1, 0);
      check_val("br_req_next", last_acc, 32'h14);

      // 5: PC wrap from FFFF_FFFC
      do_reset();
      step(0, 0, 0, 32'h0, 32'h0, 0, 1);
      step(0, 0, 1, 32'h0, 32'hFFFF_FFFF, 0, 1);
      run_until_acc(1, 1, 1, 0);
      run_until_acc(1, 1, 1, 0);
      check_val("wrap_top", last_acc, 32'hFFFF_FFFC);
      run_until_acc(1, 1, 1, 0);
      check_val("wrap_zero", last_acc, 32'h0);

      // 6: reset in WAIT, stale rvalid lands just after reset
      do_reset();
      run_until_acc(3, 1, 2, 0);
      step(0, 0, 0, 32'h0, 32'h0, 1, 2);
      check_reset_outputs("rst6");
      step(0, 0, 0, 32'h0, 32'h0, 0, 1);
      check_val("rst6_req", 32'(imem_req), 32'd1);
      check_val("rst6_addr", imem_addr, 32'h0);
      check_val("rst6_valid", 32'(instr_valid), 32'd0);
      check_val("rst6_state", 32'(dbg_state), 32'(REQ));

      // random run against the model
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         step(-1, -1, -1, 32'h0, 32'h0, ($urandom_range(0, 499) == 0) ? 1 : 0, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
